activations_writeback: RTL and testbench

//  Write-side counterpart of the activation read streamer. Takes the binarized

---
 rtl/activations_writeback_if.sv | 14 +
 rtl/activations_writeback.sv | 127 ++++++++++++
 tb/tb_activations_writeback.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/activations_writeback_if.sv
// Activation BRAM write-port bus: the write-back block drives it as master, the
// memory (or a bench monitor) observes it as slave.
interface activations_writeback_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  modport master (output mem_en, mem_we, mem_addr, mem_din);
  modport slave  (input  mem_en, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/activations_writeback.sv
// Packs the binarized activation bit stream LSB-first into DATA_W-bit words and
// writes them to consecutive BRAM addresses. Optional: ACTWB_OVERFLOW_EN adds a sticky stray-beat flag.
module activations_writeback #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      addr_start,
  input  logic [CNT_W-1:0]       batch,
  input  logic                   act_bit,
  input  logic                   act_bit_valid,
  input  logic                   act_last,
  activations_writeback_if.master mem,
  output logic                   busy,
  output logic                   done
`ifdef ACTWB_OVERFLOW_EN
  ,
  output logic                   overflow
`endif
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, PACKING} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  pack_reg, pack_next;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [CNT_W-1:0]   nwords_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic               mem_en_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [DATA_W-1:0]  mem_din_reg;
  logic               done_reg;

  logic beat, word_done, burst_end, start_accept;

  assign start_accept = (state_reg == IDLE) && start;
  assign beat         = (state_reg == PACKING) && act_bit_valid;
  assign word_done    = beat && ((bit_cnt_reg == BIT_W'(DATA_W - 1)) || act_last);
  assign burst_end    = word_done && ((word_cnt_reg == nwords_reg) || act_last);

  // Pack register with the current beat merged in at bit_cnt; this is also the
  // word written out when the beat completes it.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pack
      assign pack_next[gi] = (bit_cnt_reg == BIT_W'(gi)) ? act_bit : pack_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = PACKING;
      PACKING: if (burst_end) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == PACKING);
    done = done_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_reg     <= '0;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      nwords_reg   <= '0;
      base_reg     <= '0;
      mem_en_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      mem_en_reg <= word_done;
      done_reg   <= burst_end;
      if (word_done) begin
        mem_addr_reg <= base_reg + ADDR_W'(word_cnt_reg);
        mem_din_reg  <= pack_next;
      end
      if (start_accept) begin
        base_reg     <= addr_start;
        nwords_reg   <= batch;
        pack_reg     <= '0;
        bit_cnt_reg  <= '0;
        word_cnt_reg <= '0;
      end else if (word_done) begin
        pack_reg    <= '0;
        bit_cnt_reg <= '0;
        // Hold at the final index so a full-size batch never wraps the counter.
        if (!burst_end) word_cnt_reg <= word_cnt_reg + 1'b1;
      end else if (beat) begin
        pack_reg    <= pack_next;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

`ifdef ACTWB_OVERFLOW_EN
  logic overflow_reg;

  // Beats arriving with no burst open (including the done cycle) are lost.
  always_ff @(posedge clk) begin
    if (reset)                                overflow_reg <= 1'b0;
    else if (state_reg == IDLE && act_bit_valid) overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;
`endif

  assign mem.mem_en   = mem_en_reg;
  assign mem.mem_we   = mem_en_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign mem.mem_din  = mem_din_reg;

endmodule

// File: tb/tb_activations_writeback.sv
// Randomized and directed stimulus for activations_writeback, checked against a
// word-level model of the expected BRAM writes (address, data, cycle, done).
module tb_activations_writeback;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] addr_start;
  logic [CNT_W-1:0]  batch;
  logic              act_bit;
  logic              act_bit_valid;
  logic              act_last;
  logic              busy;
  logic              done;
`ifdef ACTWB_OVERFLOW_EN
  logic              overflow;
`endif

  activations_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  activations_writeback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .addr_start    (addr_start),
    .batch         (batch),
    .act_bit       (act_bit),
    .act_bit_valid (act_bit_valid),
    .act_last      (act_last),
    .mem           (mem_bus),
    .busy          (busy),
    .done          (done)
`ifdef ACTWB_OVERFLOW_EN
    ,
    .overflow      (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    int                cyc;
    logic              done;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                n_writes = 0;
  logic [DATA_W-1:0] last_din = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the head of the model queue exactly.
  always @(negedge clk) begin
    if (!reset) begin
      check("done_without_write", {31'b0, done & ~mem_bus.mem_en}, 32'd0);
      if (mem_bus.mem_en) begin
        n_writes++;
        last_din  = mem_bus.mem_din;
        last_addr = mem_bus.mem_addr;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {21'b0, mem_bus.mem_addr}, {21'b0, e.addr});
          check("write_din", {16'b0, mem_bus.mem_din}, {16'b0, e.din});
          check("write_cycle", cyc, e.cyc);
          check("write_done", {31'b0, done}, {31'b0, e.done});
          check("write_we", {31'b0, mem_bus.mem_we}, 32'd1);
          check("busy_at_write", {31'b0, busy}, {31'b0, ~e.done});
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_en"}, {31'b0, mem_bus.mem_en}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_bus.mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {21'b0, mem_bus.mem_addr}, 32'd0);
    check({tag, "_mem_din"}, {16'b0, mem_bus.mem_din}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
`ifdef ACTWB_OVERFLOW_EN
    check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
`endif
  endtask

  // mode: 0 random bits, 1 alternating 1,0,..., 2 all ones.
  task automatic send_burst(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] nb,
                            input int nbeats, input bit early_last, input int mode,
                            input int gap_pct, input int extra);
    logic [DATA_W-1:0] w;
    logic              bitv;
    logic              last;
    start = 1'b1; addr_start = base; batch = nb;
    act_bit_valid = 1'b0; act_last = 1'b0;
    tick();
    check("busy_after_start", {31'b0, busy}, 32'd1);
    start = 1'b0;
    w = '0;
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        act_bit_valid = 1'b0; act_last = 1'b0;
        // A start while a burst is open must be ignored.
        start = ($urandom_range(9) == 0);
        addr_start = ADDR_W'($urandom); batch = CNT_W'($urandom);
        tick();
      end
      if (mode == 1)      bitv = ~i[0];
      else if (mode == 2) bitv = 1'b1;
      else                bitv = 1'($urandom_range(1));
      last = early_last && (i == nbeats - 1);
      start = 1'b0; act_bit_valid = 1'b1; act_bit = bitv; act_last = last;
      w[i % DATA_W] = bitv;
      if ((i % DATA_W) == DATA_W - 1 || last) begin
        exp_q.push_back('{addr: ADDR_W'((int'(base) + i / DATA_W) % (1 << ADDR_W)),
                         din: w, cyc: cyc + 1,
                         done: ((i / DATA_W) == int'(nb)) || last});
        w = '0;
      end
      tick();
    end
    act_bit_valid = 1'b0; act_last = 1'b0;
    for (int k = 0; k < extra; k++) begin
      act_bit_valid = 1'b1; act_bit = 1'($urandom_range(1));
      tick();
    end
    act_bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; addr_start = '0; batch = '0;
    act_bit = 1'b0; act_bit_valid = 1'b0; act_last = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(2);

    // 1: single word, alternating pattern
    w0 = n_writes;
    send_burst(11'h010, 6'd0, 16, 1'b0, 1, 0, 0);
    idle(3);
    check("t1_writes", n_writes - w0, 1);
    check("t1_din", {16'b0, last_din}, 32'h5555);
    check("t1_addr", {21'b0, last_addr}, 32'h010);

    // 2: three full words back-to-back
    w0 = n_writes;
    send_burst(11'h020, 6'd2, 48, 1'b0, 2, 0, 0);
    idle(3);
    check("t2_writes", n_writes - w0, 3);
    check("t2_din", {16'b0, last_din}, 32'hFFFF);
    check("t2_addr", {21'b0, last_addr}, 32'h022);

    // 3: early end via act_last on the 5th beat
    w0 = n_writes;
    send_burst(11'h100, 6'd3, 5, 1'b1, 2, 0, 0);
    idle(3);
    check("t3_writes", n_writes - w0, 1);
    check("t3_din", {16'b0, last_din}, 32'h001F);
    check("t3_idle", {31'b0, busy}, 32'd0);

    // 4: address wrap at the top of the BRAM
    w0 = n_writes;
    send_burst(11'h7FF, 6'd1, 32, 1'b0, 0, 0, 0);
    idle(3);
    check("t4_writes", n_writes - w0, 2);
    check("t4_addr", {21'b0, last_addr}, 32'h000);

    // 5: reset in the middle of a word
    w0 = n_writes;
    start = 1'b1; addr_start = 11'h055; batch = 6'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      act_bit_valid = 1'b1; act_bit = 1'b1;
      tick();
    end
    act_bit_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_outputs_zero("t5_reset");
    reset = 1'b0;
    idle(2);
    check("t5_no_write", n_writes - w0, 0);
    send_burst(11'h040, 6'd0, 16, 1'b0, 1, 0, 0);
    idle(3);
    check("t5_din", {16'b0, last_din}, 32'h5555);
    check("t5_addr", {21'b0, last_addr}, 32'h040);

    // 6: stray beats while idle
    w0 = n_writes;
    for (int i = 0; i < 8; i++) begin
      act_bit_valid = 1'b1; act_bit = 1'($urandom_range(1));
      tick();
    end
    act_bit_valid = 1'b0;
    idle(3);
    check("t6_no_write", n_writes - w0, 0);
`ifdef ACTWB_OVERFLOW_EN
    check("t6_overflow_set", {31'b0, overflow}, 32'd1);
    idle(5);
    check("t6_overflow_hold", {31'b0, overflow}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_overflow_clr", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    idle(2);
`endif

    // Largest batch: 2**CNT_W words, done only on the last
    w0 = n_writes;
    send_burst(11'h3F0, 6'd63, 64 * DATA_W, 1'b0, 0, 0, 0);
    idle(3);
    check("max_batch_writes", n_writes - w0, 64);
    check("max_batch_addr", {21'b0, last_addr}, 32'h42F);

    // Randomized back-to-back bursts, gaps, early ends and stray beats
    for (int b = 0; b < 30; b++) begin
      logic [CNT_W-1:0] nb;
      bit               early;
      int               nbeats;
      nb = CNT_W'($urandom_range(3));
      early = 1'($urandom_range(1));
      nbeats = early ? int'($urandom_range(DATA_W * (int'(nb) + 1), 1))
                     : DATA_W * (int'(nb) + 1);
      send_burst(ADDR_W'($urandom), nb, nbeats, early, 0, 20, int'($urandom_range(3)));
    end
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
